debounce_filter: RTL and testbench

- Upstream conditioning stage for the edge-detector/event-counter block. Takes a raw asynchronous input (push-button, switch, encoder contact), synchronises it to CLK, and suppresses bounce.
- Delivers a clean, glitch-free level on SIGNAL_OUT. That output drives the edge detector's SIGNAL input directly, so one physical press yields exactly one RE.

---
 rtl/debounce_filter_pkg.sv | 25 ++
 rtl/debounce_filter_sync.sv | 45 ++++
 rtl/debounce_filter.sv | 192 +++++++++++++++++++
 tb/tb_debounce_filter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_filter_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
//   Shared types and helpers for the debounce_filter block.
//   - state_t        : 2-bit debouncer state encoding
//   - cnt_width()    : width of the qualification counter for a given
//                      DEBOUNCE_CYCLES, sized so DEBOUNCE_CYCLES-1 always fits
//   - GLITCH_COUNT_W : width of the optional glitch diagnostic counter
// -----------------------------------------------------------------------------
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_t;

  localparam int GLITCH_COUNT_W = 8;

  // clog2(n+1): wide enough to hold values 0..n.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/debounce_filter_sync.sv
// -----------------------------------------------------------------------------
// sync_ff_chain
//   Plain flip-flop synchroniser for an asynchronous single-bit input.
//   No logic sits between stages so the chain can be constrained as a
//   metastability resolver. Reusable for any other asynchronous input.
//
// Parameters:
//   STAGES      - number of flops in the chain (minimum 2)
//   RESET_LEVEL - value loaded into every flop while reset is asserted
//
// Ports:
//   CLK      in   system clock, rising edge
//   RESET_N  in   asynchronous active-low reset
//   async_in in   raw asynchronous input
//   sync_out out  synchronised level (last stage)
// -----------------------------------------------------------------------------
module sync_ff_chain #(
  parameter int STAGES      = 2,
  parameter bit RESET_LEVEL = 1'b0
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic async_in,
  output logic sync_out
);

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;

  // Shift toward the MSB; bit 0 is the first (metastable-prone) stage.
  always_comb begin
    chain_d = {chain_q[STAGES-2:0], async_in};
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      chain_q <= {STAGES{RESET_LEVEL}};
    end else begin
      chain_q <= chain_d;
    end
  end

  assign sync_out = chain_q[STAGES-1];

endmodule

// File: rtl/debounce_filter.sv
// -----------------------------------------------------------------------------
// debounce_filter
//   Synchronises a raw, possibly bouncing input and delivers a clean,
//   glitch-free level. A candidate transition must be seen on the
//   synchronised sample for DEBOUNCE_CYCLES+1 consecutive cycles (the entry
//   sample plus DEBOUNCE_CYCLES samples in the wait state) before
//   SIGNAL_OUT follows. Any reversal during the wait aborts the candidate
//   and produces a one-cycle GLITCH pulse.
//
// Parameters:
//   DEBOUNCE_CYCLES - stable samples required in the wait state (1 .. 2^20)
//   SYNC_STAGES     - synchroniser depth (minimum 2)
//   RESET_LEVEL     - SIGNAL_OUT and synchroniser value during reset
//
// Ports:
//   CLK          in   system clock, rising edge
//   RESET_N      in   asynchronous active-low reset
//   SIGNAL_IN    in   raw asynchronous input
//   SIGNAL_OUT   out  debounced level (registered)
//   BUSY         out  high while in WAIT_HI / WAIT_LO (registered)
//   GLITCH       out  one-cycle pulse after an aborted wait (registered)
//   dbg_state    out  current FSM state (debug observation)
//   GLITCH_COUNT out  8-bit saturating glitch count, present only when
//                     DEBOUNCE_GLITCH_COUNT_EN is defined
//
// Valid/ready: none. SIGNAL_IN is a free-running level; all outputs are
// levels/pulses valid every cycle with no backpressure.
//
// Build option:
//   DEBOUNCE_GLITCH_COUNT_EN - adds the GLITCH_COUNT diagnostic counter.
// -----------------------------------------------------------------------------
module debounce_filter
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SYNC_STAGES     = 2,
  parameter bit RESET_LEVEL     = 1'b0
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       SIGNAL_IN,
  output logic       SIGNAL_OUT,
  output logic       BUSY,
  output logic       GLITCH,
  output logic [1:0] dbg_state
`ifdef DEBOUNCE_GLITCH_COUNT_EN
  ,
  output logic [GLITCH_COUNT_W-1:0] GLITCH_COUNT
`else
  // Diagnostic glitch counter not built.
`endif
);

  localparam int               CW        = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]    CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam state_t           RST_STATE = RESET_LEVEL ? STABLE_HI : STABLE_LO;

  // ---------------------------------------------------------------------------
  // Synchroniser
  // ---------------------------------------------------------------------------
  logic s;

  sync_ff_chain #(
    .STAGES      (SYNC_STAGES),
    .RESET_LEVEL (RESET_LEVEL)
  ) u_sync (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .async_in (SIGNAL_IN),
    .sync_out (s)
  );

  // ---------------------------------------------------------------------------
  // Qualification FSM
  // ---------------------------------------------------------------------------
  state_t        state_q,  state_d;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic          out_q,    out_d;
  logic          busy_q,   busy_d;
  logic          glitch_q, glitch_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    glitch_d = 1'b0;

    case (state_q)
      STABLE_LO: begin
        if (s) begin
          state_d = WAIT_HI;
          cnt_d   = '0;
        end
      end

      WAIT_HI: begin
        // Reversal is checked first; a match needs s at the new polarity,
        // so the two can never both apply.
        if (!s) begin
          state_d  = STABLE_LO;
          cnt_d    = '0;
          glitch_d = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
          out_d   = 1'b1;
        end else begin
          // Stops at CNT_LAST, so the counter never wraps.
          cnt_d = cnt_q + 1'b1;
        end
      end

      STABLE_HI: begin
        if (!s) begin
          state_d = WAIT_LO;
          cnt_d   = '0;
        end
      end

      WAIT_LO: begin
        if (s) begin
          state_d  = STABLE_HI;
          cnt_d    = '0;
          glitch_d = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
          out_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = RST_STATE;
        cnt_d   = '0;
      end
    endcase

    // BUSY is registered from the next state so it tracks state_q exactly.
    busy_d = (state_d == WAIT_HI) || (state_d == WAIT_LO);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= RST_STATE;
      cnt_q    <= '0;
      out_q    <= RESET_LEVEL;
      busy_q   <= 1'b0;
      glitch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      busy_q   <= busy_d;
      glitch_q <= glitch_d;
    end
  end

  assign SIGNAL_OUT = out_q;
  assign BUSY       = busy_q;
  assign GLITCH     = glitch_q;
  assign dbg_state  = state_q;

  // ---------------------------------------------------------------------------
  // Optional glitch diagnostic counter
  // ---------------------------------------------------------------------------
`ifdef DEBOUNCE_GLITCH_COUNT_EN
  logic [GLITCH_COUNT_W-1:0] gcnt_q, gcnt_d;

  // Counts on glitch_d so the count updates on the same edge GLITCH rises.
  always_comb begin
    gcnt_d = gcnt_q;
    if (glitch_d && (gcnt_q != {GLITCH_COUNT_W{1'b1}})) begin
      gcnt_d = gcnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      gcnt_q <= '0;
    end else begin
      gcnt_q <= gcnt_d;
    end
  end

  assign GLITCH_COUNT = gcnt_q;
`else
  // No glitch counter register in this build.
`endif

endmodule

// File: tb/tb_debounce_filter.sv
// -----------------------------------------------------------------------------
// tb_debounce_filter
//   Directed bench for debounce_filter (DEBOUNCE_CYCLES=4, SYNC_STAGES=2,
//   RESET_LEVEL=0) plus a second instance with DEBOUNCE_CYCLES=1 sharing the
//   same input. Inputs change 1 ns after a rising edge; the raw value set
//   before edge k is sampled by the FSM at edge k+2, so a held step reaches
//   SIGNAL_OUT at edge k+6 (k+3 for the DEBOUNCE_CYCLES=1 instance).
// -----------------------------------------------------------------------------
module tb_debounce_filter;

  logic       CLK;
  logic       RESET_N;
  logic       SIGNAL_IN;
  logic       SIGNAL_OUT, BUSY, GLITCH;
  logic [1:0] dbg_state;
  logic       out1, busy1, glitch1;
  logic [1:0] dbg_state1;
`ifdef DEBOUNCE_GLITCH_COUNT_EN
  logic [7:0] GLITCH_COUNT;
  logic [7:0] glitch_count1;
`endif

  int checks = 0;
  int errors = 0;

  // Event counters, written only by the monitor below.
  int glitch_cnt = 0;
  int rise_cnt   = 0;
  int fall_cnt   = 0;
  logic out_prev = 1'b0;
  int base_glitch, base_rise, base_fall;

  debounce_filter #(
    .DEBOUNCE_CYCLES (4),
    .SYNC_STAGES     (2),
    .RESET_LEVEL     (1'b0)
  ) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .SIGNAL_IN  (SIGNAL_IN),
    .SIGNAL_OUT (SIGNAL_OUT),
    .BUSY       (BUSY),
    .GLITCH     (GLITCH),
    .dbg_state  (dbg_state)
`ifdef DEBOUNCE_GLITCH_COUNT_EN
    ,
    .GLITCH_COUNT (GLITCH_COUNT)
`endif
  );

  debounce_filter #(
    .DEBOUNCE_CYCLES (1),
    .SYNC_STAGES     (2),
    .RESET_LEVEL     (1'b0)
  ) dut1 (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .SIGNAL_IN  (SIGNAL_IN),
    .SIGNAL_OUT (out1),
    .BUSY       (busy1),
    .GLITCH     (glitch1),
    .dbg_state  (dbg_state1)
`ifdef DEBOUNCE_GLITCH_COUNT_EN
    ,
    .GLITCH_COUNT (glitch_count1)
`endif
  );

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Monitor on the falling edge, away from the active edge.
  always @(negedge CLK) begin
    if (RESET_N) begin
      if (GLITCH === 1'b1) glitch_cnt = glitch_cnt + 1;
      if (SIGNAL_OUT === 1'b1 && out_prev === 1'b0) rise_cnt = rise_cnt + 1;
      if (SIGNAL_OUT === 1'b0 && out_prev === 1'b1) fall_cnt = fall_cnt + 1;
    end
    out_prev = SIGNAL_OUT;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    base_glitch = glitch_cnt;
    base_rise   = rise_cnt;
    base_fall   = fall_cnt;
  endtask

  initial begin
    // ---------------- Reset with input held high ----------------
    RESET_N   = 1'b0;
    SIGNAL_IN = 1'b1;
    #23;
    check("rst_out",    32'(SIGNAL_OUT), 32'd0);
    check("rst_busy",   32'(BUSY),       32'd0);
    check("rst_glitch", 32'(GLITCH),     32'd0);
    check("rst_state",  32'(dbg_state),  32'd0);
    check("rst_out1",   32'(out1),       32'd0);

    // Release between edges; the next edge is edge 1.
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    tick(2);   // edges 1,2: synchroniser filling
    check("rel_busy_e2", 32'(BUSY), 32'd0);
    tick(1);   // edge 3: enters WAIT_HI
    check("rel_busy_e3",  32'(BUSY),      32'd1);
    check("rel_state_e3", 32'(dbg_state), 32'd1);
    tick(3);   // edge 6
    check("rel_out_e6",  32'(SIGNAL_OUT), 32'd0);
    check("rel_busy_e6", 32'(BUSY),       32'd1);
    tick(1);   // edge 7
    check("rel_out_e7",  32'(SIGNAL_OUT), 32'd1);
    check("rel_busy_e7", 32'(BUSY),       32'd0);
    check("rel_state_e7", 32'(dbg_state), 32'd2);

    // ---------------- Return low ----------------
    SIGNAL_IN = 1'b0;
    tick(6);
    check("low_out_e6", 32'(SIGNAL_OUT), 32'd1);
    tick(1);
    check("low_out_e7", 32'(SIGNAL_OUT), 32'd0);
    tick(2);
    check("low_state", 32'(dbg_state), 32'd0);

    // ---------------- Clean step, held 20 cycles ----------------
    snap();
    SIGNAL_IN = 1'b1;
    tick(2);   // edges k, k+1
    check("step_busy_k1", 32'(BUSY), 32'd0);
    tick(1);   // k+2
    check("step_busy_k2",  32'(BUSY),  32'd1);
    check("step_busy1_k2", 32'(busy1), 32'd1);
    check("step_out1_k2",  32'(out1),  32'd0);
    tick(1);   // k+3
    check("step_out1_k3",  32'(out1),  32'd1);
    check("step_busy1_k3", 32'(busy1), 32'd0);
    tick(2);   // k+5
    check("step_out_k5",  32'(SIGNAL_OUT), 32'd0);
    check("step_busy_k5", 32'(BUSY),       32'd1);
    tick(1);   // k+6
    check("step_out_k6",  32'(SIGNAL_OUT), 32'd1);
    check("step_busy_k6", 32'(BUSY),       32'd0);
    tick(13);
    check("step_rises",   32'(rise_cnt - base_rise),     32'd1);
    check("step_falls",   32'(fall_cnt - base_fall),     32'd0);
    check("step_glitch",  32'(glitch_cnt - base_glitch), 32'd0);

    SIGNAL_IN = 1'b0;
    tick(8);
    check("step_back_low", 32'(SIGNAL_OUT), 32'd0);

    // ---------------- Bounce burst then settle high ----------------
    snap();
    SIGNAL_IN = 1'b1; tick(2);
    SIGNAL_IN = 1'b0; tick(2);
    SIGNAL_IN = 1'b1; tick(2);
    SIGNAL_IN = 1'b0; tick(2);
    SIGNAL_IN = 1'b1;          // settles at edge k
    tick(6);                   // k+5
    check("bounce_out_k5", 32'(SIGNAL_OUT), 32'd0);
    tick(1);                   // k+6
    check("bounce_out_k6", 32'(SIGNAL_OUT), 32'd1);
    tick(6);
    check("bounce_glitch", 32'(glitch_cnt - base_glitch), 32'd2);
    check("bounce_rises",  32'(rise_cnt - base_rise),     32'd1);
    check("bounce_falls",  32'(fall_cnt - base_fall),     32'd0);

    SIGNAL_IN = 1'b0;
    tick(8);
    check("bounce_back_low", 32'(SIGNAL_OUT), 32'd0);

    // ---------------- Short pulses: 1 cycle, then 4 cycles ----------------
    snap();
    SIGNAL_IN = 1'b1; tick(1);
    SIGNAL_IN = 1'b0; tick(3);
    SIGNAL_IN = 1'b1; tick(4);
    SIGNAL_IN = 1'b0; tick(10);
    check("short_out",    32'(SIGNAL_OUT),               32'd0);
    check("short_rises",  32'(rise_cnt - base_rise),     32'd0);
    check("short_glitch", 32'(glitch_cnt - base_glitch), 32'd2);
    check("short_busy",   32'(BUSY),                     32'd0);

    // ---------------- Reset asserted mid-wait ----------------
    snap();
    SIGNAL_IN = 1'b1;
    tick(3);   // k+2: WAIT_HI
    check("midrst_busy_before", 32'(BUSY), 32'd1);
    #2;
    RESET_N = 1'b0;
    #1;        // no clock edge yet: reset must act asynchronously
    check("midrst_out",    32'(SIGNAL_OUT), 32'd0);
    check("midrst_busy",   32'(BUSY),       32'd0);
    check("midrst_glitch", 32'(GLITCH),     32'd0);
    check("midrst_state",  32'(dbg_state),  32'd0);
    SIGNAL_IN = 1'b0;
    tick(2);
    RESET_N = 1'b1;
    tick(10);
    check("midrst_no_glitch", 32'(glitch_cnt - base_glitch), 32'd0);
    check("midrst_out_after", 32'(SIGNAL_OUT),               32'd0);

`ifdef DEBOUNCE_GLITCH_COUNT_EN
    // ---------------- Saturating glitch counter ----------------
    check("gcnt_reset", 32'(GLITCH_COUNT), 32'd0);
    for (int i = 0; i < 10; i++) begin
      SIGNAL_IN = 1'b1; tick(1);
      SIGNAL_IN = 1'b0; tick(1);
    end
    tick(5);
    check("gcnt_10", 32'(GLITCH_COUNT), 32'd10);
    for (int i = 0; i < 290; i++) begin
      SIGNAL_IN = 1'b1; tick(1);
      SIGNAL_IN = 1'b0; tick(1);
    end
    tick(5);
    check("gcnt_sat", 32'(GLITCH_COUNT), 32'd255);
    tick(10);
    check("gcnt_hold", 32'(GLITCH_COUNT), 32'd255);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
